// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch_lap block.
// Optional lap FIFO is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

    function automatic int pre_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/stopwatch_lap_fifo.sv
// Synchronous first-word fall-through FIFO holding captured lap times.
// Head reads as zero while empty so the consumer never sees stale data.
module lap_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_i && !empty_o)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i)
            mem[wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/stopwatch_lap.sv
// Prescaled stopwatch with start/stop/clear, sticky overflow and lap capture.
// Lap FIFO is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int PRESCALE  = 1,
    parameter int LAP_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic             lap_i,
    input  logic             lap_ready_i,
    output logic [WIDTH-1:0] time_o,
    output logic             running_o,
    output logic             overflow_o,
    output logic             lap_valid_o,
    output logic [WIDTH-1:0] lap_time_o,
    output logic             lap_overrun_o
);

    localparam int            PW   = pre_width(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    state_e           state;
    state_e           state_n;
    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] time_q;
    logic             ovf;
    logic             tick;

    assign tick = (state == RUN) && (pre == PMAX);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start_i && !stop_i) state_n = RUN;
            RUN:     if (stop_i) state_n = PAUSED;
            PAUSED:  if (start_i && !stop_i) state_n = RUN;
            default: state_n = IDLE;
        endcase
        if (clear_i)
            state_n = IDLE;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Prescaler phase survives a pause so resumed timing stays exact.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pre    <= '0;
            time_q <= '0;
            ovf    <= 1'b0;
        end else if (clear_i) begin
            pre    <= '0;
            time_q <= '0;
            ovf    <= 1'b0;
        end else if (state == RUN) begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick) begin
                time_q <= time_q + WIDTH'(1);
                if (&time_q)
                    ovf <= 1'b1;
            end
        end
    end

    assign time_o     = time_q;
    assign running_o  = (state == RUN);
    assign overflow_o = ovf;

`ifdef STOPWATCH_LAP_EN
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic overrun;

    assign pop  = !empty && lap_ready_i;
    assign push = lap_i && !clear_i && (state != IDLE);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            overrun <= 1'b0;
        else if (clear_i)
            overrun <= 1'b0;
        else if (push && full && !pop)
            overrun <= 1'b1;
    end

    lap_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (LAP_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .flush_i  (clear_i),
        .push_i   (push && (!full || pop)),
        .pop_i    (pop),
        .data_i   (time_q),
        .data_o   (lap_time_o),
        .full_o   (full),
        .empty_o  (empty)
    );

    assign lap_valid_o   = !empty;
    assign lap_overrun_o = overrun;
`else
    logic unused_lap;
    assign unused_lap    = lap_i ^ lap_ready_i;
    assign lap_valid_o   = 1'b0;
    assign lap_time_o    = '0;
    assign lap_overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: two instances (W4/P1 and W16/P4) driven in lockstep.
// Expected values come from constants and a run-cycle-count reference model.
module tb_stopwatch_lap;

    localparam int WA = 4;
    localparam int PA = 1;
    localparam int WB = 16;
    localparam int PB = 4;
    localparam int D  = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_ni, start_i, stop_i, clear_i, lap_i, lap_ready_i;

    logic [WA-1:0] a_time, a_lap_time;
    logic          a_run, a_ovf, a_lv, a_lov;
    logic [WB-1:0] b_time, b_lap_time;
    logic          b_run, b_ovf, b_lv, b_lov;

    always #5 clk = ~clk;

    stopwatch_lap #(.WIDTH(WA), .PRESCALE(PA), .LAP_DEPTH(D)) dut_a (
        .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i),
        .stop_i(stop_i), .clear_i(clear_i), .lap_i(lap_i),
        .lap_ready_i(lap_ready_i), .time_o(a_time), .running_o(a_run),
        .overflow_o(a_ovf), .lap_valid_o(a_lv), .lap_time_o(a_lap_time),
        .lap_overrun_o(a_lov)
    );

    stopwatch_lap #(.WIDTH(WB), .PRESCALE(PB), .LAP_DEPTH(D)) dut_b (
        .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i),
        .stop_i(stop_i), .clear_i(clear_i), .lap_i(lap_i),
        .lap_ready_i(lap_ready_i), .time_o(b_time), .running_o(b_run),
        .overflow_o(b_ovf), .lap_valid_o(b_lv), .lap_time_o(b_lap_time),
        .lap_overrun_o(b_lov)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 run, 2 paused; n = edges spent in RUN.
    int     m_mode [2];
    longint m_n    [2];
    bit     m_lov  [2];
    int     q0 [$];
    int     q1 [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint m_ticks(input int i);
        longint p;
        p = (i == 0) ? PA : PB;
        return m_n[i] / p;
    endfunction

    function automatic int m_time(input int i);
        int w;
        w = (i == 0) ? WA : WB;
        return int'(m_ticks(i) % (longint'(1) << w));
    endfunction

    function automatic bit m_ovf(input int i);
        int w;
        w = (i == 0) ? WA : WB;
        return m_ticks(i) >= (longint'(1) << w);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_n[i]    = 0;
            m_lov[i]  = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int q [$];
            int cur;
            bit pop, push;
            if (i == 0) q = q0; else q = q1;
            cur = m_time(i);
            if (clear_i) begin
                m_mode[i] = 0;
                m_n[i]    = 0;
                m_lov[i]  = 1'b0;
                q.delete();
            end else begin
                pop  = LAP && q.size() > 0 && lap_ready_i;
                push = LAP && lap_i && m_mode[i] != 0;
                if (m_mode[i] == 1) m_n[i]++;
                if (push && q.size() >= D && !pop) m_lov[i] = 1'b1;
                else if (push) begin
                    if (pop) void'(q.pop_front());
                    q.push_back(cur);
                    pop = 1'b0;
                end
                if (pop) void'(q.pop_front());
                if (stop_i) begin
                    if (m_mode[i] == 1) m_mode[i] = 2;
                end else if (start_i && m_mode[i] != 1) begin
                    m_mode[i] = 1;
                end
            end
            if (i == 0) q0 = q; else q1 = q;
        end
    endtask

    task automatic check_model(input string tag);
        int h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : 0;
        h1 = (q1.size() > 0) ? q1[0] : 0;
        chk({tag, "_a_time"}, 32'(a_time), m_time(0));
        chk({tag, "_a_run"}, 32'(a_run), 32'(m_mode[0] == 1));
        chk({tag, "_a_ovf"}, 32'(a_ovf), 32'(m_ovf(0)));
        chk({tag, "_a_lv"}, 32'(a_lv), 32'(q0.size() > 0));
        chk({tag, "_a_lt"}, 32'(a_lap_time), h0);
        chk({tag, "_a_lov"}, 32'(a_lov), 32'(m_lov[0]));
        chk({tag, "_b_time"}, 32'(b_time), m_time(1));
        chk({tag, "_b_run"}, 32'(b_run), 32'(m_mode[1] == 1));
        chk({tag, "_b_ovf"}, 32'(b_ovf), 32'(m_ovf(1)));
        chk({tag, "_b_lv"}, 32'(b_lv), 32'(q1.size() > 0));
        chk({tag, "_b_lt"}, 32'(b_lap_time), h1);
        chk({tag, "_b_lov"}, 32'(b_lov), 32'(m_lov[1]));
    endtask

    task automatic cyc(input bit st, input bit sp, input bit cl,
                       input bit lp, input bit rd);
        start_i     = st;
        stop_i      = sp;
        clear_i     = cl;
        lap_i       = lp;
        lap_ready_i = rd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_cyc(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit st;
        bit sp;
        bit cl;
        int t;
        bit run;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 1};
        tbl[1]  = '{0, 0, 0, 1, 1};
        tbl[2]  = '{0, 0, 0, 2, 1};
        tbl[3]  = '{0, 1, 0, 3, 0};
        tbl[4]  = '{0, 0, 0, 3, 0};
        tbl[5]  = '{0, 1, 0, 3, 0};
        tbl[6]  = '{1, 0, 0, 3, 1};
        tbl[7]  = '{0, 0, 0, 4, 1};
        tbl[8]  = '{1, 0, 0, 5, 1};
        tbl[9]  = '{1, 1, 1, 0, 0};
        tbl[10] = '{0, 1, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 0, 1};

        reset_ni = 1'b0;
        {start_i, stop_i, clear_i, lap_i, lap_ready_i} = '0;
        model_reset();
        #12;
        chk("rst_a_time", 32'(a_time), 0);
        chk("rst_a_run", 32'(a_run), 0);
        chk("rst_b_ovf", 32'(b_ovf), 0);
        chk("rst_a_lv", 32'(a_lv), 0);
        chk("rst_a_lt", 32'(a_lap_time), 0);
        chk("rst_a_lov", 32'(a_lov), 0);
        reset_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].st, tbl[i].sp, tbl[i].cl, 0, 0);
            chk($sformatf("tbl%0d_time", i), 32'(a_time), tbl[i].t);
            chk($sformatf("tbl%0d_run", i), 32'(a_run), 32'(tbl[i].run));
        end

        // Wrap at WIDTH=4 sets sticky overflow; clear drops it.
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle_cyc(15);
        chk("wrap_pre_time", 32'(a_time), 15);
        chk("wrap_pre_ovf", 32'(a_ovf), 0);
        cyc(0, 0, 0, 0, 0);
        chk("wrap_time", 32'(a_time), 0);
        chk("wrap_ovf", 32'(a_ovf), 1);
        idle_cyc(3);
        chk("wrap_ovf_sticky", 32'(a_ovf), 1);
        cyc(0, 0, 1, 0, 0);
        chk("clr_time", 32'(a_time), 0);
        chk("clr_ovf", 32'(a_ovf), 0);
        chk("clr_run", 32'(a_run), 0);

        // PRESCALE=4: held phase across a pause.
        cyc(1, 0, 0, 0, 0);
        idle_cyc(17);
        chk("ps_run17", 32'(b_time), 4);
        cyc(0, 1, 0, 0, 0);
        chk("ps_stop_time", 32'(b_time), 4);
        chk("ps_stop_run", 32'(b_run), 0);
        idle_cyc(5);
        chk("ps_paused", 32'(b_time), 4);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("ps_resume1", 32'(b_time), 4);
        cyc(0, 0, 0, 0, 0);
        chk("ps_resume2", 32'(b_time), 5);

        if (LAP) begin
            cyc(0, 0, 1, 0, 0);
            cyc(1, 0, 0, 0, 0);
            for (int j = 0; j < 12; j++)
                cyc(0, 0, 0, (j % 2 == 1) && j >= 3, 0);
            cyc(0, 1, 0, 0, 0);
            chk("lap_valid", 32'(a_lv), 1);
            chk("lap_overrun", 32'(a_lov), 1);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("lap_drain%0d", k), 32'(a_lap_time), 3 + 2 * k);
                cyc(0, 0, 0, 0, 1);
            end
            chk("lap_empty", 32'(a_lv), 0);
            chk("lap_ovr_sticky", 32'(a_lov), 1);

            cyc(0, 0, 1, 0, 0);
            cyc(1, 0, 0, 0, 0);
            for (int j = 0; j < 4; j++) cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 1, 1);
            chk("pp_overrun", 32'(a_lov), 0);
            chk("pp_head", 32'(a_lap_time), 1);
            cyc(0, 1, 0, 0, 0);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("pp_drain%0d", k), 32'(a_lap_time), 1 + k);
                cyc(0, 0, 0, 0, 1);
            end
            cyc(1, 0, 0, 1, 0);
            cyc(1, 1, 1, 1, 0);
            chk("flush_valid", 32'(a_lv), 0);
            chk("flush_time", 32'(a_time), 0);
            chk("flush_run", 32'(a_run), 0);
        end else begin
            cyc(0, 0, 0, 1, 1);
            chk("nolap_valid", 32'(a_lv), 0);
            chk("nolap_time", 32'(a_lap_time), 0);
            chk("nolap_ovr", 32'(a_lov), 0);
        end
        check_model("seq");

        // Asynchronous reset between edges.
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0);
        idle_cyc(6);
        @(negedge clk);
        reset_ni = 1'b0;
        #1;
        chk("arst_a_time", 32'(a_time), 0);
        chk("arst_a_run", 32'(a_run), 0);
        chk("arst_b_time", 32'(b_time), 0);
        chk("arst_b_run", 32'(b_run), 0);
        chk("arst_a_lv", 32'(a_lv), 0);
        chk("arst_a_lt", 32'(a_lap_time), 0);
        model_reset();
        #1;
        reset_ni = 1'b1;

        for (int r = 0; r < 800; r++) begin
            cyc($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
                $urandom_range(0, 199) < 3, $urandom_range(0, 99) < 35,
                $urandom_range(0, 99) < 25);
            check_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
